// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns a field bundle into a 32-bit word with a sequential word address.
// Optional delay-slot NOP padding after BEQ/BNE/J is enabled by defining ENCODER_DELAY_SLOT_PAD_EN.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [9:0]  BaseAddr,
  input  logic        InValid,
  output logic        InReady,
  input  logic [3:0]  InstrSel,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  input  logic [4:0]  Shamt,
  input  logic [15:0] Imm,
  input  logic [25:0] Target,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutWord,
  output logic [9:0]  OutAddr,
  output logic        IllegalErr,
  output logic        Wrapped
);

`ifdef ENCODER_DELAY_SLOT_PAD_EN
  typedef enum logic {ENC, PAD} state_e;
`else
  typedef enum logic {ENC} state_e;
`endif

  state_e      state_q;
  logic        outValid_q, outValid_d;
  logic [31:0] outWord_q, outWord_d;
  logic [9:0]  addr_q, addr_d;
  logic        illegal_q, illegal_d;
  logic        wrapped_q, wrapped_d;

  logic [31:0] encWord;
  logic        encLegal;
  logic        outFree;
  logic        accept;
  logic        outXfer;

  assign outFree  = !outValid_q || OutReady;
  assign InReady  = outFree && (state_q == ENC);
  assign accept   = InValid && InReady;
  assign outXfer  = outValid_q && OutReady;

  assign OutValid   = outValid_q;
  assign OutWord    = outWord_q;
  assign OutAddr    = addr_q;
  assign IllegalErr = illegal_q;
  assign Wrapped    = wrapped_q;

  always_comb begin
    encWord  = '0;
    encLegal = 1'b1;
    case (InstrSel)
      4'd0:    encWord = {6'h00, Rs, Rt, Rd, 5'd0, 6'h21};
      4'd1:    encWord = {6'h00, Rs, Rt, Rd, 5'd0, 6'h23};
      4'd2:    encWord = {6'h00, 5'd0, Rt, Rd, Shamt, 6'h00};
      4'd3:    encWord = {6'h00, 5'd0, Rt, Rd, Shamt, 6'h02};
      4'd4:    encWord = {6'h00, Rs, Rt, Rd, 5'd0, 6'h2A};
      4'd5:    encWord = {6'h04, Rs, Rt, Imm};
      4'd6:    encWord = {6'h05, Rs, Rt, Imm};
      4'd7:    encWord = {6'h0A, Rs, Rt, Imm};
      4'd8:    encWord = {6'h0D, Rs, Rt, Imm};
      4'd9:    encWord = {6'h23, Rs, Rt, Imm};
      4'd10:   encWord = {6'h0F, 5'd0, Rt, Imm};
      4'd11:   encWord = {6'h2B, Rs, Rt, Imm};
      4'd12:   encWord = {6'h02, Target};
      default: encLegal = 1'b0;
    endcase
  end

`ifdef ENCODER_DELAY_SLOT_PAD_EN
  logic isBranch;
  assign isBranch = (InstrSel == 4'd5) || (InstrSel == 4'd6) || (InstrSel == 4'd12);
`endif

  // Start wins over a same-cycle transfer: that word keeps the old address, the next uses BaseAddr.
  always_comb begin
    outValid_d = outValid_q;
    outWord_d  = outWord_q;
    addr_d     = addr_q;
    illegal_d  = illegal_q;
    wrapped_d  = wrapped_q;
    if (outXfer) outValid_d = 1'b0;
    if (accept && encLegal) begin
      outValid_d = 1'b1;
      outWord_d  = encWord;
    end
`ifdef ENCODER_DELAY_SLOT_PAD_EN
    if (state_q == PAD && outFree) begin
      outValid_d = 1'b1;
      outWord_d  = '0;
    end
`endif
    if (Start) begin
      addr_d    = BaseAddr;
      illegal_d = 1'b0;
      wrapped_d = 1'b0;
    end else if (outXfer) begin
      addr_d = addr_q + 10'd1;
      if (addr_q == 10'h3FF) wrapped_d = 1'b1;
    end
    if (accept && !encLegal) illegal_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ENC;
      outValid_q <= 1'b0;
      outWord_q  <= '0;
      addr_q     <= '0;
      illegal_q  <= 1'b0;
      wrapped_q  <= 1'b0;
    end else begin
      outValid_q <= outValid_d;
      outWord_q  <= outWord_d;
      addr_q     <= addr_d;
      illegal_q  <= illegal_d;
      wrapped_q  <= wrapped_d;
`ifdef ENCODER_DELAY_SLOT_PAD_EN
      case (state_q)
        ENC: if (accept && encLegal && isBranch) state_q <= PAD;
        PAD: if (outFree) state_q <= ENC;
        default: state_q <= ENC;
      endcase
`else
      state_q <= ENC;
`endif
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed MIPS words.
// Padding checks are enabled when ENCODER_DELAY_SLOT_PAD_EN is defined.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [9:0]  BaseAddr;
  logic        InValid;
  logic        InReady;
  logic [3:0]  InstrSel;
  logic [4:0]  Rs, Rt, Rd, Shamt;
  logic [15:0] Imm;
  logic [25:0] Target;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutWord;
  logic [9:0]  OutAddr;
  logic        IllegalErr;
  logic        Wrapped;

  int testCount = 0;
  int failCount = 0;

`ifdef ENCODER_DELAY_SLOT_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif

  typedef struct {
    logic [3:0]  sel;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [31:0] expWord;
  } vec_t;

  vec_t vecs[6] = '{
    '{4'd3,  5'd9,  5'd10, 5'd11, 5'd31, 16'h0000, 32'h000A5FC2},
    '{4'd10, 5'd5,  5'd6,  5'd0,  5'd0,  16'h1234, 32'h3C061234},
    '{4'd8,  5'd2,  5'd3,  5'd0,  5'd0,  16'h00FF, 32'h344300FF},
    '{4'd11, 5'd29, 5'd31, 5'd0,  5'd0,  16'h0008, 32'hAFBF0008},
    '{4'd4,  5'd1,  5'd2,  5'd3,  5'd5,  16'h0000, 32'h0022182A},
    '{4'd7,  5'd4,  5'd4,  5'd0,  5'd0,  16'hFFFE, 32'h2884FFFE}
  };

  instr_encoder dut (
    .clk(clk), .rst(rst), .Start(Start), .BaseAddr(BaseAddr),
    .InValid(InValid), .InReady(InReady), .InstrSel(InstrSel),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Imm(Imm), .Target(Target),
    .OutValid(OutValid), .OutReady(OutReady), .OutWord(OutWord), .OutAddr(OutAddr),
    .IllegalErr(IllegalErr), .Wrapped(Wrapped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                               input logic [25:0] tgt);
    InstrSel = sel; Rs = rs; Rt = rt; Rd = rd; Shamt = sh; Imm = imm; Target = tgt;
    InValid  = 1'b1;
    #1;
  endtask

  task automatic pulseStart(input logic [9:0] base);
    Start = 1'b1; BaseAddr = base;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    logic [9:0] a;
    rst = 1'b1; Start = 1'b0; BaseAddr = '0; InValid = 1'b0; InstrSel = '0;
    Rs = '0; Rt = '0; Rd = '0; Shamt = '0; Imm = '0; Target = '0; OutReady = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_valid",   {31'd0, OutValid},   32'd0);
    checkOutput("rst_word",    OutWord,             32'd0);
    checkOutput("rst_addr",    {22'd0, OutAddr},    32'd0);
    checkOutput("rst_illegal", {31'd0, IllegalErr}, 32'd0);
    checkOutput("rst_wrapped", {31'd0, Wrapped},    32'd0);
    checkOutput("rst_inready", {31'd0, InReady},    32'd1);

    // Mixed R/I-type table streamed back to back from address 0.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, 26'd0);
      tick();
      checkOutput($sformatf("tbl_word%0d", i), OutWord, vecs[i].expWord);
      checkOutput($sformatf("tbl_addr%0d", i), {22'd0, OutAddr}, i);
    end
    InValid = 1'b0;
    tick();

    // ADDU at base 0x010, latency 1.
    pulseStart(10'h010);
    applyStimulus(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    checkOutput("addu_inready", {31'd0, InReady}, 32'd1);
    tick();
    InValid = 1'b0;
    checkOutput("addu_valid", {31'd0, OutValid}, 32'd1);
    checkOutput("addu_word",  OutWord,           32'h00221821);
    checkOutput("addu_addr",  {22'd0, OutAddr},  32'h010);
    tick();
    checkOutput("addu_drain", {31'd0, OutValid}, 32'd0);

    // LW then SLL back to back from 0.
    pulseStart(10'h000);
    applyStimulus(4'd9, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
    tick();
    checkOutput("lw_word", OutWord,          32'h8FA80004);
    checkOutput("lw_addr", {22'd0, OutAddr}, 32'h000);
    applyStimulus(4'd2, 5'd7, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0);
    tick();
    InValid = 1'b0;
    checkOutput("sll_valid", {31'd0, OutValid}, 32'd1);
    checkOutput("sll_word",  OutWord,           32'h00031100);
    checkOutput("sll_addr",  {22'd0, OutAddr},  32'h001);
    tick();

    // BEQ held under backpressure.
    OutReady = 1'b0;
    applyStimulus(4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
    tick();
    InValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("beq_hold_word%0d", i), OutWord, 32'h1022FFFF);
      checkOutput($sformatf("beq_hold_addr%0d", i), {22'd0, OutAddr}, 32'h002);
      checkOutput($sformatf("beq_hold_valid%0d", i), {31'd0, OutValid}, 32'd1);
      checkOutput($sformatf("beq_hold_inready%0d", i), {31'd0, InReady}, 32'd0);
      tick();
    end
    OutReady = 1'b1;
    #1;
    checkOutput("beq_release_inready", {31'd0, InReady}, PadEn ? 32'd0 : 32'd1);
    tick();
    if (PadEn) begin
      checkOutput("pad_valid", {31'd0, OutValid}, 32'd1);
      checkOutput("pad_word",  OutWord,           32'h00000000);
      checkOutput("pad_addr",  {22'd0, OutAddr},  32'h003);
      tick();
    end
    checkOutput("beq_drained", {31'd0, OutValid}, 32'd0);
    a = PadEn ? 10'h004 : 10'h003;

    // Illegal select consumed without output.
    applyStimulus(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    checkOutput("ill_inready", {31'd0, InReady}, 32'd1);
    tick();
    InValid = 1'b0;
    checkOutput("ill_novalid", {31'd0, OutValid},   32'd0);
    checkOutput("ill_err",     {31'd0, IllegalErr}, 32'd1);

    applyStimulus(4'd12, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
    tick();
    InValid = 1'b0;
    checkOutput("j_word",   OutWord,             32'h08100000);
    checkOutput("j_addr",   {22'd0, OutAddr},    {22'd0, a});
    checkOutput("j_sticky", {31'd0, IllegalErr}, 32'd1);
    tick();
    if (PadEn) begin
      checkOutput("j_pad_word", OutWord,          32'h00000000);
      checkOutput("j_pad_addr", {22'd0, OutAddr}, {22'd0, a + 10'd1});
      tick();
    end

    // Wrap from 0x3FF; Start also clears the sticky illegal flag.
    pulseStart(10'h3FF);
    checkOutput("start_clr_ill", {31'd0, IllegalErr}, 32'd0);
    applyStimulus(4'd0, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
    tick();
    checkOutput("wrap_w0",    OutWord,          32'h00853021);
    checkOutput("wrap_a0",    {22'd0, OutAddr}, 32'h3FF);
    checkOutput("wrap_pre",   {31'd0, Wrapped}, 32'd0);
    applyStimulus(4'd1, 5'd7, 5'd8, 5'd9, 5'd3, 16'h0, 26'h0);
    tick();
    InValid = 1'b0;
    checkOutput("wrap_w1",    OutWord,          32'h00E84823);
    checkOutput("wrap_a1",    {22'd0, OutAddr}, 32'h000);
    checkOutput("wrap_flag",  {31'd0, Wrapped}, 32'd1);

    // Reset while a word is held.
    OutReady = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mrst_valid",   {31'd0, OutValid},   32'd0);
    checkOutput("mrst_word",    OutWord,             32'd0);
    checkOutput("mrst_addr",    {22'd0, OutAddr},    32'd0);
    checkOutput("mrst_wrapped", {31'd0, Wrapped},    32'd0);
    checkOutput("mrst_illegal", {31'd0, IllegalErr}, 32'd0);
    checkOutput("mrst_inready", {31'd0, InReady},    32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have these ports, one per line as name  direction  width  meaning; clock and reset are listed first.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- Start  in  1  pulse: loads the address counter from BaseAddr and clears the status flags.
- BaseAddr  in  10  word address loaded on Start.
- InValid  in  1  field bundle valid.
- InReady  out  1  block accepts the bundle this cycle.
- InstrSel  in  4  0 ADDU, 1 SUBU, 2 SLL, 3 SRL, 4 SLT, 5 BEQ, 6 BNE, 7 SLTI, 8 ORI, 9 LW, 10 LUI, 11 SW, 12 J; 13-15 are illegal.
- Rs, Rt, Rd, Shamt  in  5 each  register and shift fields.
- Imm  in  16  immediate or branch offset.
- Target  in  26  jump target.
- OutValid  out  1  encoded word valid.
- OutReady  in  1  downstream (instruction-memory writer) accepts the word.
- OutWord  out  32  encoded MIPS instruction.
- OutAddr  out  10  word address for OutWord.
- IllegalErr  out  1  sticky; an illegal InstrSel was accepted.
- Wrapped  out  1  sticky; the address counter wrapped from 1023 to 0.

Function
REQ-002 Handshakes SHALL be:
- input transfer occurs when InValid && InReady;
- output transfer occurs when OutValid && OutReady.
REQ-003 Output stage SHALL be a single register.
- InReady = (!OutValid || OutReady) && state==ENC.
- Accepted legal bundle appears on OutWord the next cycle (latency 1).
- Back-to-back throughput is 1 word/cycle.
REQ-004 Opcode and funct encoding SHALL be:
- R-type: opcode 0x00; funct ADDU 0x21, SUBU 0x23, SLL 0x00, SRL 0x02, SLT 0x2A.
- Opcodes: BEQ 0x04, BNE 0x05, SLTI 0x0A, ORI 0x0D, LUI 0x0F, LW 0x23, SW 0x2B, J 0x02.
REQ-005 Field placement SHALL be:
- R-type: {op, Rs, Rt, Rd, Shamt, funct}; SLL/SRL force the rs field to 0; ADDU/SUBU/SLT force the shamt field to 0.
- I-type: {op, Rs, Rt, Imm}; LUI forces the rs field to 0.
- J: {op, Target}.
REQ-006 Illegal InstrSel SHALL be consumed (InReady honoured) with no word emitted; IllegalErr is set the cycle after acceptance.
REQ-007 OutAddr SHALL equal the address counter.
- Counter increments by 1 on each output transfer, modulo 1024.
- Increment from 1023 sets Wrapped.
REQ-008 FSM states SHALL be ENC and PAD.
- ENC: normal operation.
- PAD: exists only with the configuration macro defined (REQ-013).
REQ-009 Start SHALL take priority over a same-cycle output transfer for the counter value.
- Word transferred in that cycle uses the old address.
- Next word uses BaseAddr.
REQ-010 OutValid SHALL hold with stable OutWord/OutAddr until transferred.

Reset
REQ-011 When rst=1 at a clock edge, the block SHALL return to its reset state.
- State ENC, OutValid 0, OutWord 0, OutAddr 0.
- IllegalErr 0, Wrapped 0.
- Any pending pad is discarded.
REQ-012 Reset asserted mid-transfer SHALL drop the held word; InReady is 1 the cycle after reset deasserts.

Configuration
REQ-013 Macro ENCODER_DELAY_SLOT_PAD_EN SHALL control delay-slot padding.
- Defined: after a BEQ, BNE or J word is loaded into the output register, FSM goes to PAD.
- In PAD: InReady=0. When the output register frees, load NOP 0x00000000 at the next address, then return to ENC.
- Not defined: no NOPs are inserted, the PAD state does not exist, and branches behave like any other instruction.

Verification
REQ-014 Bench SHALL cover:
- Start BaseAddr=0x010, ADDU Rs=1 Rt=2 Rd=3 -> OutWord 0x00221821 at OutAddr 0x010, one cycle after accept.
- LW Rt=8 Rs=29 Imm=0x0004, then SLL Rd=2 Rt=3 Shamt=4 Rs=7 back-to-back with OutReady=1 -> 0x8FA80004 @0x000, 0x00031100 @0x001 on consecutive cycles.
- BEQ Rs=1 Rt=2 Imm=0xFFFF with OutReady held 0 for 3 cycles -> 0x1022FFFF held stable, InReady=0; with ENCODER_DELAY_SLOT_PAD_EN -> 0x00000000 follows at the next address.
- InstrSel=14 -> no OutValid, IllegalErr=1 next cycle; J Target=0x0100000 -> 0x08100000.
- Start BaseAddr=0x3FF, two words -> addresses 0x3FF, 0x000, Wrapped=1; rst asserted while OutValid=1 -> all outputs 0 next cycle.
